// File: rtl/butterfly_cordic_pipe_if.sv
// Streaming butterfly bus: input sample with twiddle/control, output pair,
// valid/ready in both directions and the sticky overflow flag.
//   slave  : view of the butterfly itself
//   master : view of the upstream/downstream stage driving it
interface butterfly_cordic_pipe_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ANGLE_BITS = 16
);
  logic                       valid_i;
  logic                       ready_o;
  logic [ANGLE_BITS-1:0]      twid_i;
  logic                       inv_i;
  logic                       scale_i;
  logic [1:0][DATA_WIDTH-1:0] a_i;
  logic [1:0][DATA_WIDTH-1:0] b_i;
  logic [1:0][DATA_WIDTH-1:0] a_o;
  logic [1:0][DATA_WIDTH-1:0] b_o;
  logic                       valid_o;
  logic                       ready_i;
  logic                       ovf_o;

  modport slave (
    input  valid_i, twid_i, inv_i, scale_i, a_i, b_i, ready_i,
    output ready_o, a_o, b_o, valid_o, ovf_o
  );

  modport master (
    output valid_i, twid_i, inv_i, scale_i, a_i, b_i, ready_i,
    input  ready_o, a_o, b_o, valid_o, ovf_o
  );
endinterface

// File: rtl/butterfly_cordic_pipe.sv
// Fully pipelined radix-2 butterfly with CORDIC twiddle rotation.
//   a_o = a + W*b, b_o = a - W*b, W = e^(-/+ j*2*pi*k/2^ANGLE_BITS) (inv_i selects +)
//   Optional per-sample halving (scale_i, round-half-up). One butterfly per cycle.
// Ports:
//   clk_i  : clock
//   rst    : synchronous active-high reset
//   bus    : butterfly_cordic_pipe_if.slave (valid/ready in, twid/inv/scale,
//            a/b in, a/b out, valid/ready out, sticky ovf_o)
// Build option:
//   BFLY_SAT_EN : clamp butterfly results to DATA_WIDTH and flag ovf_o;
//                 when undefined results wrap and ovf_o is tied low.
// Latency is ITERS+3 enabled cycles: quadrant, ITERS micro-rotations, gain, butterfly.
module butterfly_cordic_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 15,
  parameter int unsigned ITERS      = 14,
  parameter int unsigned ANGLE_BITS = FRAC_BITS + 1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  butterfly_cordic_pipe_if.slave bus
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned XW   = DW + 2;          // CORDIC datapath
  localparam int unsigned ZW   = ANGLE_BITS + 2;  // angle accumulator
  localparam int unsigned GW   = DW + 1;          // rotated b after gain
  localparam int unsigned SW   = DW + 2;          // butterfly sums
  localparam int unsigned GC_W = FRAC_BITS + 2;   // signed gain constant
  localparam int unsigned PW   = XW + GC_W;       // gain product
  localparam real         PI   = 3.14159265358979;

  // Elaboration-time helpers (real arithmetic only, no math library needed)
  function automatic real pow2r(input int n);
    real r;
    r = 1.0;
    for (int i = 0; i < n; i++) r = r * 2.0;
    return r;
  endfunction

  // atan(2^-i) in angle codes (2^ANGLE_BITS per turn), Taylor series for i>0
  function automatic int atan_code(input int i);
    real x, term, acc, sgn;
    if (i == 0) begin
      acc = PI / 4.0;
    end else begin
      x    = 1.0 / pow2r(i);
      term = x;
      acc  = 0.0;
      sgn  = 1.0;
      for (int n = 0; n < 40; n++) begin
        acc  = acc + sgn * term / $itor(2 * n + 1);
        term = term * x * x;
        sgn  = -sgn;
      end
    end
    return $rtoi(acc * pow2r(int'(ANGLE_BITS)) / (2.0 * PI) + 0.5);
  endfunction

  // round(2^FRAC_BITS / K), K = prod sqrt(1 + 2^-2i); sqrt via Newton iteration
  function automatic int gain_code();
    real k2, s;
    k2 = 1.0;
    for (int i = 0; i < int'(ITERS); i++) k2 = k2 * (1.0 + 1.0 / pow2r(2 * i));
    s = k2;
    for (int n = 0; n < 40; n++) s = 0.5 * (s + k2 / s);
    return $rtoi(pow2r(int'(FRAC_BITS)) / s + 0.5);
  endfunction

  localparam logic signed [GC_W-1:0] GAIN_S = GC_W'(gain_code());
  localparam logic signed [PW-1:0]   HALF_S = $signed(PW'(1) << (FRAC_BITS - 1));
  localparam logic signed [SW-1:0]   ONE_S  = $signed(SW'(1));
  localparam logic signed [SW-1:0]   S_MAX  = $signed(SW'({1'b0, {(DW-1){1'b1}}}));
  localparam logic signed [SW-1:0]   S_MIN  = ~S_MAX;

  // Two's complement negate that maps the most negative code to the maximum
  function automatic logic signed [DW-1:0] sneg(input logic signed [DW-1:0] v);
    if (v == $signed({1'b1, {(DW-1){1'b0}}})) return $signed({1'b0, {(DW-1){1'b1}}});
    return -v;
  endfunction

  // Arithmetic right shift with round-half-up, keeps the CORDIC error zero-mean
  function automatic logic signed [XW-1:0] rsh(input logic signed [XW-1:0] v,
                                               input int unsigned sh);
    logic signed [XW-1:0] bias;
    if (sh == 0) return v;
    bias = $signed(XW'(1) << (sh - 1));
    return (v + bias) >>> sh;
  endfunction

`ifdef BFLY_SAT_EN
  // {saturated, value}: optional halving then clamp to DW bits
  function automatic logic [DW:0] narrow(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] v;
    v = sc ? ((s + ONE_S) >>> 1) : s;
    if (v > S_MAX) return {1'b1, DW'(S_MAX)};
    if (v < S_MIN) return {1'b1, DW'(S_MIN)};
    return {1'b0, DW'(v)};
  endfunction
`else
  // Optional halving then wrap to DW bits
  function automatic logic [DW-1:0] narrow(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] v;
    v = sc ? ((s + ONE_S) >>> 1) : s;
    return DW'(v);
  endfunction
`endif

  // Pipeline registers
  logic                  r_valid_o;
  logic [1:0][DW-1:0]    r_a_o;
  logic [1:0][DW-1:0]    r_b_o;
  logic [ITERS+1:0]      r_vld;
  logic [ITERS+1:0]      r_sc;
  logic [1:0][DW-1:0]    r_a [0:ITERS+1];
  logic signed [XW-1:0]  r_x [0:ITERS];
  logic signed [XW-1:0]  r_y [0:ITERS];
  logic signed [ZW-1:0]  r_z [0:ITERS-1];
  logic signed [GW-1:0]  r_gx;
  logic signed [GW-1:0]  r_gy;

  logic                  w_en;
  logic [ANGLE_BITS-1:0] w_rot;
  logic signed [DW-1:0]  w_bre, w_bim, w_qx, w_qy;

  // Global enable: advance unless a valid output is being held back
  assign w_en        = bus.ready_i | ~r_valid_o;
  assign bus.ready_o = w_en;

  // Counter-clockwise rotation code: -k for forward, +k for inverse
  assign w_rot = bus.inv_i ? bus.twid_i : ANGLE_BITS'(0) - bus.twid_i;
  assign w_bre = $signed(bus.b_i[0]);
  assign w_bim = $signed(bus.b_i[1]);

  // Quadrant pre-rotation by multiples of 90 degrees
  always_comb begin
    w_qx = w_bre;
    w_qy = w_bim;
    unique case (w_rot[ANGLE_BITS-1 -: 2])
      2'd0: begin w_qx = w_bre;       w_qy = w_bim;       end
      2'd1: begin w_qx = sneg(w_bim); w_qy = w_bre;       end
      2'd2: begin w_qx = sneg(w_bre); w_qy = sneg(w_bim); end
      default: begin w_qx = w_bim;    w_qy = sneg(w_bre); end
    endcase
  end

  // Stage valid bits and scale delay line
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[ITERS:0], bus.valid_i};
    end
  end

  // Data stage 0 and the a/scale delay lines (no reset needed on data)
  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_x[0] <= XW'(w_qx);
      r_y[0] <= XW'(w_qy);
      r_z[0] <= $signed(ZW'(w_rot[ANGLE_BITS-3:0]));
      r_a[0] <= bus.a_i;
      r_sc   <= {r_sc[ITERS:0], bus.scale_i};
      for (int k = 1; k <= int'(ITERS) + 1; k++) r_a[k] <= r_a[k-1];
    end
  end

  // CORDIC micro-rotation stages 1..ITERS
  for (genvar gi = 1; gi <= int'(ITERS); gi++) begin : g_stage
    localparam int unsigned          SH     = gi - 1;
    localparam logic signed [ZW-1:0] ATAN_C = ZW'(atan_code(gi - 1));
    logic signed [XW-1:0] w_xs, w_ys;
    logic                 w_neg;

    assign w_xs  = rsh(r_x[gi-1], SH);
    assign w_ys  = rsh(r_y[gi-1], SH);
    assign w_neg = r_z[gi-1][ZW-1];

    always_ff @(posedge clk_i) begin
      if (w_en) begin
        if (!w_neg) begin
          r_x[gi] <= r_x[gi-1] - w_ys;
          r_y[gi] <= r_y[gi-1] + w_xs;
        end else begin
          r_x[gi] <= r_x[gi-1] + w_ys;
          r_y[gi] <= r_y[gi-1] - w_xs;
        end
      end
    end

    // Last stage needs no residual angle
    if (gi < int'(ITERS)) begin : g_z
      always_ff @(posedge clk_i) begin
        if (w_en) r_z[gi] <= w_neg ? r_z[gi-1] + ATAN_C : r_z[gi-1] - ATAN_C;
      end
    end
  end

  // CORDIC gain compensation, rounded
  logic signed [PW-1:0] w_px, w_py;
  assign w_px = PW'(r_x[ITERS]) * PW'(GAIN_S);
  assign w_py = PW'(r_y[ITERS]) * PW'(GAIN_S);

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_gx <= GW'((w_px + HALF_S) >>> FRAC_BITS);
      r_gy <= GW'((w_py + HALF_S) >>> FRAC_BITS);
    end
  end

  // Butterfly sums
  logic signed [SW-1:0] w_are, w_aim, w_gre, w_gim;
  logic [DW-1:0]        w_oar, w_oai, w_obr, w_obi;
  logic                 w_sc;

  assign w_are = SW'($signed(r_a[ITERS+1][0]));
  assign w_aim = SW'($signed(r_a[ITERS+1][1]));
  assign w_gre = SW'(r_gx);
  assign w_gim = SW'(r_gy);
  assign w_sc  = r_sc[ITERS+1];

`ifdef BFLY_SAT_EN
  logic [DW:0] w_nar, w_nai, w_nbr, w_nbi;
  logic        w_sat;
  logic        r_ovf;

  assign w_nar = narrow(w_are + w_gre, w_sc);
  assign w_nai = narrow(w_aim + w_gim, w_sc);
  assign w_nbr = narrow(w_are - w_gre, w_sc);
  assign w_nbi = narrow(w_aim - w_gim, w_sc);
  assign w_oar = w_nar[DW-1:0];
  assign w_oai = w_nai[DW-1:0];
  assign w_obr = w_nbr[DW-1:0];
  assign w_obi = w_nbi[DW-1:0];
  assign w_sat = w_nar[DW] | w_nai[DW] | w_nbr[DW] | w_nbi[DW];

  // Sticky flag, set when a clamped sample is presented
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_en && r_vld[ITERS+1] && w_sat) begin
      r_ovf <= 1'b1;
    end
  end
  assign bus.ovf_o = r_ovf;
`else
  assign w_oar = narrow(w_are + w_gre, w_sc);
  assign w_oai = narrow(w_aim + w_gim, w_sc);
  assign w_obr = narrow(w_are - w_gre, w_sc);
  assign w_obi = narrow(w_aim - w_gim, w_sc);
  assign bus.ovf_o = 1'b0;
`endif

  // Output register, held while downstream stalls
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_valid_o <= 1'b0;
      r_a_o     <= '0;
      r_b_o     <= '0;
    end else if (w_en) begin
      r_valid_o <= r_vld[ITERS+1];
      if (r_vld[ITERS+1]) begin
        r_a_o[0] <= w_oar;
        r_a_o[1] <= w_oai;
        r_b_o[0] <= w_obr;
        r_b_o[1] <= w_obi;
      end
    end
  end

  assign bus.valid_o = r_valid_o;
  assign bus.a_o     = r_a_o;
  assign bus.b_o     = r_b_o;

endmodule

// File: tb/tb_butterfly_cordic_pipe.sv
// Directed and streamed checks of butterfly_cordic_pipe (default parameters).
module tb_butterfly_cordic_pipe;
  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 15;
  localparam int unsigned ITERS = 14;
  localparam int unsigned AB    = 16;
  localparam int          LAT   = 17;
  localparam real         PI    = 3.14159265358979;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  butterfly_cordic_pipe_if #(.DATA_WIDTH(DW), .ANGLE_BITS(AB)) bus ();

  butterfly_cordic_pipe #(
    .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .ITERS(ITERS), .ANGLE_BITS(AB)
  ) dut (
    .clk_i(clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Floating-point reference butterfly
  function automatic void model(input int k, input bit inv, input bit sc,
                                input int ar, input int ai, input int br, input int bi,
                                output int oar, output int oai, output int obr, output int obi);
    real th, c, s, wr, wi, d;
    th  = 2.0 * PI * $itor(k) / 65536.0;
    c   = $cos(th);
    s   = inv ? $sin(th) : -$sin(th);
    wr  = c * $itor(br) - s * $itor(bi);
    wi  = c * $itor(bi) + s * $itor(br);
    d   = sc ? 2.0 : 1.0;
    oar = $rtoi($floor(($itor(ar) + wr) / d + 0.5));
    oai = $rtoi($floor(($itor(ai) + wi) / d + 0.5));
    obr = $rtoi($floor(($itor(ar) - wr) / d + 0.5));
    obi = $rtoi($floor(($itor(ai) - wi) / d + 0.5));
  endfunction

  task automatic drive(input int k, input bit inv, input bit sc,
                       input int ar, input int ai, input int br, input int bi);
    bus.twid_i  = AB'(k);
    bus.inv_i   = inv;
    bus.scale_i = sc;
    bus.a_i[0]  = DW'(ar);
    bus.a_i[1]  = DW'(ai);
    bus.b_i[0]  = DW'(br);
    bus.b_i[1]  = DW'(bi);
  endtask

  // One sample through an empty pipeline; checks latency and both outputs
  task automatic run_dir(input string tag, input int k, input bit inv, input bit sc,
                         input int ar, input int ai, input int br, input int bi,
                         input int ear, input int eai, input int ebr, input int ebi,
                         input int tol);
    int n;
    drive(k, inv, sc, ar, ai, br, bi);
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    n = 1;
    while (!bus.valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, LAT, 0);
    chk({tag, "_a_re"}, sx(bus.a_o[0]), ear, tol);
    chk({tag, "_a_im"}, sx(bus.a_o[1]), eai, tol);
    chk({tag, "_b_re"}, sx(bus.b_o[0]), ebr, tol);
    chk({tag, "_b_im"}, sx(bus.b_o[1]), ebi, tol);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int ar;
    int ai;
    int br;
    int bi;
  } exp_t;

  exp_t q[$];

  initial begin
    int sent, rcvd, cyc, seen;
    bit in_t, out_t;
    int k, ar, ai, br, bi;
    bit inv, sc;
    exp_t e;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.valid_o), 0, 0);
    chk("rst_a_re", sx(bus.a_o[0]), 0, 0);
    chk("rst_b_im", sx(bus.b_o[1]), 0, 0);
    chk("rst_ovf", int'(bus.ovf_o), 0, 0);
    chk("rst_ready", int'(bus.ready_o), 1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, expectations from a +/- W*b by hand
    run_dir("k0",     0,     1'b0, 1'b0, 16384, 0,     8192,   0,     24576, 0,      8192,   0,     2);
    run_dir("q1fwd",  16384, 1'b0, 1'b0, 16384, 8192,  8192,  -8192,  8192,  0,      24576,  16384, 3);
    run_dir("q1inv",  16384, 1'b1, 1'b0, 16384, 8192,  8192,  -8192,  24576, 16384,  8192,   0,     3);
    run_dir("k3_8",   24576, 1'b0, 1'b0, 16384, 0,     16384,  0,     4799,  -11585, 27969,  11585, 4);
    run_dir("kmaxi",  65535, 1'b1, 1'b0, 0,     0,     16384,  0,     16384, -2,     -16384, 2,     2);
    run_dir("kmaxf",  65535, 1'b0, 1'b0, 0,     0,     16384,  0,     16384, 2,      -16384, -2,    2);
    run_dir("negsat", 32768, 1'b0, 1'b1, 0,     0,     -32768, 0,     16384, 0,      -16384, 0,     2);
    chk("ovf_clear", int'(bus.ovf_o), 0, 0);

`ifdef BFLY_SAT_EN
    run_dir("sat",    0, 1'b0, 1'b0, 24576, 0, 24576, 0, 32767, 0, 0, 0, 2);
    chk("sat_ovf", int'(bus.ovf_o), 1, 0);
    run_dir("sat_sc", 0, 1'b0, 1'b1, 24576, 0, 24576, 0, 24576, 0, 0, 0, 2);
    chk("sat_ovf_hold", int'(bus.ovf_o), 1, 0);
`else
    run_dir("wrap",    0, 1'b0, 1'b0, 24576, 0, 24576, 0, -16384, 0, 0, 0, 2);
    chk("wrap_ovf", int'(bus.ovf_o), 0, 0);
    run_dir("wrap_sc", 0, 1'b0, 1'b1, 24576, 0, 24576, 0, 24576, 0, 0, 0, 2);
    chk("wrap_ovf_sc", int'(bus.ovf_o), 0, 0);
`endif

    // Random stream with random back-pressure
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((sent < 32 || rcvd < 32) && cyc < 3000) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      if (!bus.valid_i && sent < 32 && $urandom_range(0, 3) != 0) begin
        k   = int'($urandom_range(0, 65535));
        inv = 1'($urandom_range(0, 1));
        sc  = 1'($urandom_range(0, 1));
        ar  = int'($urandom_range(0, 22000)) - 11000;
        ai  = int'($urandom_range(0, 22000)) - 11000;
        br  = int'($urandom_range(0, 22000)) - 11000;
        bi  = int'($urandom_range(0, 22000)) - 11000;
        drive(k, inv, sc, ar, ai, br, bi);
        model(k, inv, sc, ar, ai, br, bi, e.ar, e.ai, e.br, e.bi);
        bus.valid_i = 1'b1;
      end
      #1;
      if (bus.valid_o) begin
        if (q.size() == 0) begin
          chk("strm_dup", int'(bus.valid_o), 0, 0);
        end else begin
          chk("strm_a_re", sx(bus.a_o[0]), q[0].ar, 4);
          chk("strm_a_im", sx(bus.a_o[1]), q[0].ai, 4);
          chk("strm_b_re", sx(bus.b_o[0]), q[0].br, 4);
          chk("strm_b_im", sx(bus.b_o[1]), q[0].bi, 4);
        end
      end
      out_t = bus.valid_o && bus.ready_i;
      in_t  = bus.valid_i && bus.ready_o;
      if (in_t) q.push_back(e);
      @(posedge clk); #1;
      if (out_t && q.size() > 0) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (in_t) begin
        sent++;
        bus.valid_i = 1'b0;
      end
      cyc++;
    end
    chk("strm_count", rcvd, 32, 0);
    chk("strm_left", q.size(), 0, 0);

    // Fill the pipeline, then pulse reset for one cycle
    bus.ready_i = 1'b1;
    drive(1000, 1'b0, 1'b0, 5000, 0, 3000, 0);
    bus.valid_i = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("prst_valid", int'(bus.valid_o), 0, 0);
    chk("prst_a_re", sx(bus.a_o[0]), 0, 0);
    chk("prst_b_re", sx(bus.b_o[0]), 0, 0);
    chk("prst_ovf", int'(bus.ovf_o), 0, 0);
    seen = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen++;
    end
    chk("prst_stale", seen, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
